// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states and op classification.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND   = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR    = 4'b0011;
    localparam logic [OP_W-1:0] OP_SLT   = 4'b0100;
    localparam logic [OP_W-1:0] OP_SGT   = 4'b0101;
    localparam logic [OP_W-1:0] OP_NOR   = 4'b0110;
    localparam logic [OP_W-1:0] OP_XOR   = 4'b0111;
    localparam logic [OP_W-1:0] OP_SLL   = 4'b1000;
    localparam logic [OP_W-1:0] OP_SRL   = 4'b1001;
    localparam logic [OP_W-1:0] OP_MULT  = 4'b1010;
    localparam logic [OP_W-1:0] OP_MULTU = 4'b1011;
    localparam logic [OP_W-1:0] OP_DIV   = 4'b1100;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'b1101;
    localparam logic [OP_W-1:0] OP_MFHI  = 4'b1110;
    localparam logic [OP_W-1:0] OP_MFLO  = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

    typedef struct packed {
        logic is_single;
        logic is_mul;
        logic is_div;
        logic is_signed;
    } op_class_t;

    // Splits the opcode space into single-cycle, iterative multiply and iterative divide.
    function automatic op_class_t classify(input logic [OP_W-1:0] op);
        op_class_t c;
        c.is_mul    = (op == OP_MULT) || (op == OP_MULTU);
        c.is_div    = (op == OP_DIV)  || (op == OP_DIVU);
        c.is_single = !(c.is_mul || c.is_div);
        c.is_signed = (op == OP_MULT) || (op == OP_DIV);
        return c;
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations; overflow is signed (operand signs vs result sign), not carry-out.
module alu_comb
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic [OP_W-1:0]        op,
    input  logic [DATA_WIDTH-1:0]  operand1,
    input  logic [DATA_WIDTH-1:0]  operand2,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic [DATA_WIDTH-1:0]  hi,
    input  logic [DATA_WIDTH-1:0]  lo,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   overflow
);

    localparam int W = DATA_WIDTH;

    logic [W-1:0] sum;
    logic [W-1:0] diff;

    assign sum  = operand1 + operand2;
    assign diff = operand1 - operand2;

    // Select the operation result and flag signed overflow for ADD/SUB.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned, which would infer a latch.
        result   = '0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                result   = sum;
                overflow = (operand1[W-1] == operand2[W-1]) && (sum[W-1] != operand1[W-1]);
            end
            OP_SUB: begin
                result   = diff;
                overflow = (operand1[W-1] != operand2[W-1]) && (diff[W-1] != operand1[W-1]);
            end
            OP_AND:  result = operand1 & operand2;
            OP_OR:   result = operand1 | operand2;
            OP_NOR:  result = ~(operand1 | operand2);
            OP_XOR:  result = operand1 ^ operand2;
            OP_SLT:  result = {{(W-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
            OP_SGT:  result = {{(W-1){1'b0}}, ($signed(operand1) > $signed(operand2))};
            OP_SLL:  result = operand2 << shamt;
            OP_SRL:  result = operand2 >> shamt;
            OP_MFHI: result = hi;
            OP_MFLO: result = lo;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ops plus iterative multiply/divide writing HI/LO,
// with a start/busy/done handshake for pipeline stalling.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_WIDTH   = 4,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SEL_WIDTH-1:0]   opSel,
    input  logic [DATA_WIDTH-1:0]  operand1,
    input  logic [DATA_WIDTH-1:0]  operand2,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic [DATA_WIDTH-1:0]  result,
    output logic [DATA_WIDTH-1:0]  hi,
    output logic [DATA_WIDTH-1:0]  lo,
    output logic                   zero,
    output logic                   overflow,
    output logic                   divByZero,
    output logic                   busy,
    output logic                   done
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;      // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
    logic [W-1:0]   mcand;    // multiplicand magnitude or divisor magnitude
    logic           op_mul;
    logic           neg_q;    // negate product / quotient at FIX
    logic           neg_r;    // negate remainder at FIX (dividend sign)
    logic           div0_q;
    logic           ovf_q;

    logic [W-1:0] comb_result;
    logic         comb_overflow;

    alu_comb #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHAMT_WIDTH(SHAMT_WIDTH)
    ) u_comb (
        .op      (opSel[OP_W-1:0]),
        .operand1(operand1),
        .operand2(operand2),
        .shamt   (shamt),
        .hi      (hi),
        .lo      (lo),
        .result  (comb_result),
        .overflow(comb_overflow)
    );

    op_class_t    cls;
    logic         sign1, sign2;
    logic [W-1:0] mag1, mag2;
    logic         div0, div_ovf;

    assign cls     = classify(opSel[OP_W-1:0]);
    assign sign1   = cls.is_signed & operand1[W-1];
    assign sign2   = cls.is_signed & operand2[W-1];
    assign mag1    = sign1 ? -operand1 : operand1;
    assign mag2    = sign2 ? -operand2 : operand2;
    assign div0    = cls.is_div && (operand2 == '0);
    assign div_ovf = cls.is_div && cls.is_signed &&
                     (operand1 == {1'b1, {(W-1){1'b0}}}) && (operand2 == '1);

    // One shift-add step: add multiplicand on multiplier LSB, shift right.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, acc[W-1:1]};

    // One restoring-divide step: shift in next dividend bit, subtract if it fits.
    logic [W:0]     div_shift;
    logic           div_ge;
    logic [W-1:0]   div_diff;
    logic [2*W-1:0] div_next;
    assign div_shift = acc[2*W-1:W-1];
    assign div_ge    = div_shift >= {1'b0, mcand};
    assign div_diff  = div_shift[W-1:0] - mcand;
    assign div_next  = div_ge ? {div_diff, acc[W-2:0], 1'b1}
                              : {div_shift[W-1:0], acc[W-2:0], 1'b0};

    // Sign correction applied in FIX.
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;
    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[W-1:0] : acc[W-1:0];
    assign rem_fix  = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
    assign fix_hi   = op_mul ? prod_fix[2*W-1:W] : rem_fix;
    assign fix_lo   = op_mul ? prod_fix[W-1:0]   : quo_fix;

    // Control FSM with all outputs registered; accepts a new op in IDLE or DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            op_mul    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            result    <= '0;
            hi        <= '0;
            lo        <= '0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
            divByZero <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees pre-edge values.
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (state == DONE) state <= IDLE;
                    if (start) begin
                        if (cls.is_single) begin
                            result   <= comb_result;
                            zero     <= (comb_result == '0);
                            overflow <= comb_overflow;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            busy   <= 1'b1;
                            cnt    <= '0;
                            op_mul <= cls.is_mul;
                            neg_q  <= sign1 ^ sign2;
                            neg_r  <= sign1;
                            div0_q <= div0;
                            ovf_q  <= div_ovf;
                            if (cls.is_mul) begin
                                mcand <= mag1;
                                acc   <= {{W{1'b0}}, mag2};
                                state <= MUL;
                            end else if (div0) begin
                                // Preload the divide-by-zero answer; FIX passes it through unsigned.
                                mcand <= '0;
                                acc   <= {operand1, {W{1'b1}}};
                                neg_q <= 1'b0;
                                neg_r <= 1'b0;
                                state <= FIX;
                            end else begin
                                mcand <= mag2;
                                acc   <= {{W{1'b0}}, mag1};
                                state <= DIV;
                            end
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W-1)) state <= FIX;
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W-1)) state <= FIX;
                end
                FIX: begin
                    hi       <= fix_hi;
                    lo       <= fix_lo;
                    result   <= fix_lo;
                    zero     <= (fix_lo == '0);
                    overflow <= ovf_q;
                    if (!op_mul) divByZero <= div0_q;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed testbench for alu_multicycle with hand-computed expectations.
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   opSel;
    logic [W-1:0] operand1, operand2;
    logic [4:0]   shamt;
    logic [W-1:0] result, hi, lo;
    logic         zero, overflow, divByZero, busy, done;

    int checks   = 0;
    int failures = 0;

    alu_multicycle #(.DATA_WIDTH(W), .SEL_WIDTH(4), .SHAMT_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .start(start), .opSel(opSel),
        .operand1(operand1), .operand2(operand2), .shamt(shamt),
        .result(result), .hi(hi), .lo(lo), .zero(zero), .overflow(overflow),
        .divByZero(divByZero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   sh;
        logic [W-1:0] exp;
    } vec_t;

    // Issue one op and wait (bounded) for done; cycles counts edges until done is seen.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] sh, output int cycles);
        @(negedge clk);
        opSel = op; operand1 = a; operand2 = b; shamt = sh; start = 1'b1;
        cycles = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end while (!done && cycles < 200);
        if (!done) begin
            checks++; failures++;
            $display("FAIL run_op timeout op=%b: done never rose within %0d cycles", op, cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; opSel = '0; operand1 = '0; operand2 = '0; shamt = '0;
        repeat (2) @(negedge clk);
        checks++; if (result !== 0 || hi !== 0 || lo !== 0) begin failures++;
            $display("FAIL reset_data result=%h hi=%h lo=%h expected all 0", result, hi, lo); end
        checks++; if ({zero, overflow, divByZero, busy, done} !== 5'b10000) begin failures++;
            $display("FAIL reset_flags got %b expected 10000", {zero, overflow, divByZero, busy, done}); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        int c;
        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, c);
        checks++; if (c !== 1) begin failures++; $display("FAIL add_latency got %0d expected 1", c); end
        checks++; if (result !== 32'h8000_0000 || overflow !== 1'b1 || zero !== 1'b0) begin failures++;
            $display("FAIL add_pos_ovf result=%h ovf=%b zero=%b expected 80000000 1 0", result, overflow, zero); end
        run_op(OP_ADD, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, c);
        checks++; if (result !== 32'h7FFF_FFFF || overflow !== 1'b1) begin failures++;
            $display("FAIL add_neg_ovf result=%h ovf=%b expected 7fffffff 1", result, overflow); end
        run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, 5'd0, c);
        checks++; if (result !== 32'h0 || overflow !== 1'b0 || zero !== 1'b1) begin failures++;
            $display("FAIL add_carry_no_ovf result=%h ovf=%b zero=%b expected 0 0 1", result, overflow, zero); end
    endtask

    task automatic test_sub();
        int c;
        run_op(OP_SUB, 32'd5, 32'd5, 5'd0, c);
        checks++; if (result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0) begin failures++;
            $display("FAIL sub_zero result=%h zero=%b ovf=%b expected 0 1 0", result, zero, overflow); end
        run_op(OP_SUB, 32'h8000_0000, 32'h1, 5'd0, c);
        checks++; if (result !== 32'h7FFF_FFFF || overflow !== 1'b1) begin failures++;
            $display("FAIL sub_ovf result=%h ovf=%b expected 7fffffff 1", result, overflow); end
    endtask

    task automatic test_logic();
        vec_t v [10];
        int   c;
        v[0] = '{OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0,  32'h00F0_1200};
        v[1] = '{OP_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd0,  32'hFFF0_FF34};
        v[2] = '{OP_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0,  32'hFF00_ED34};
        v[3] = '{OP_NOR, 32'h0F0F_0000, 32'h00F0_00FF, 5'd0,  32'hF000_FF00};
        v[4] = '{OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001};
        v[5] = '{OP_SLT, 32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000};
        v[6] = '{OP_SGT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000};
        v[7] = '{OP_SGT, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0001};
        v[8] = '{OP_SLL, 32'h1234_5678, 32'h0000_0003, 5'd30, 32'hC000_0000};
        v[9] = '{OP_SRL, 32'h1234_5678, 32'h8000_0000, 5'd31, 32'h0000_0001};
        for (int i = 0; i < 10; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, v[i].sh, c);
            checks++; if (result !== v[i].exp || zero !== (v[i].exp == 0) || c !== 1) begin failures++;
                $display("FAIL logic_vec%0d op=%b result=%h zero=%b cycles=%0d expected %h %b 1",
                         i, v[i].op, result, zero, c, v[i].exp, (v[i].exp == 0)); end
        end
    endtask

    task automatic test_mult();
        int c;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0, c);
        checks++; if (c !== 34) begin failures++; $display("FAIL mult_latency got %0d expected 34", c); end
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB || result !== 32'hFFFF_FFEB || overflow !== 1'b0) begin failures++;
            $display("FAIL mult_signed hi=%h lo=%h result=%h ovf=%b expected ffffffff ffffffeb ffffffeb 0",
                     hi, lo, result, overflow); end
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, c);
        checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin failures++;
            $display("FAIL multu_max hi=%h lo=%h expected fffffffe 00000001", hi, lo); end
        run_op(OP_MFHI, 32'h0, 32'h0, 5'd0, c);
        checks++; if (result !== 32'hFFFF_FFFE || c !== 1) begin failures++;
            $display("FAIL mfhi_after_multu result=%h cycles=%0d expected fffffffe 1", result, c); end
        run_op(OP_MFLO, 32'h0, 32'h0, 5'd0, c);
        checks++; if (result !== 32'h1) begin failures++;
            $display("FAIL mflo_after_multu result=%h expected 00000001", result); end
    endtask

    task automatic test_div_zero();
        int c;
        run_op(OP_DIVU, 32'd9, 32'd0, 5'd0, c);
        checks++; if (c !== 2) begin failures++; $display("FAIL div0_latency got %0d expected 2", c); end
        checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd9 || divByZero !== 1'b1 || overflow !== 1'b0) begin failures++;
            $display("FAIL div0_values lo=%h hi=%h dbz=%b ovf=%b expected ffffffff 00000009 1 0",
                     lo, hi, divByZero, overflow); end
        run_op(OP_MFHI, 32'h0, 32'h0, 5'd0, c);
        checks++; if (result !== 32'd9 || divByZero !== 1'b1) begin failures++;
            $display("FAIL mfhi_after_div0 result=%h dbz=%b expected 00000009 1", result, divByZero); end
    endtask

    task automatic test_div();
        int c;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, c);
        checks++; if (c !== 34) begin failures++; $display("FAIL div_latency got %0d expected 34", c); end
        checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || result !== 32'hFFFF_FFFD) begin failures++;
            $display("FAIL div_neg_dividend lo=%h hi=%h result=%h expected fffffffd ffffffff fffffffd", lo, hi, result); end
        checks++; if (divByZero !== 1'b0) begin failures++;
            $display("FAIL div_clears_dbz dbz=%b expected 0", divByZero); end
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd0, c);
        checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin failures++;
            $display("FAIL div_neg_divisor lo=%h hi=%h expected fffffffd 00000001", lo, hi); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, c);
        checks++; if (lo !== 32'h8000_0000 || hi !== 32'h0 || overflow !== 1'b1) begin failures++;
            $display("FAIL div_min_by_neg1 lo=%h hi=%h ovf=%b expected 80000000 0 1", lo, hi, overflow); end
        run_op(OP_DIVU, 32'd100, 32'd7, 5'd0, c);
        checks++; if (lo !== 32'd14 || hi !== 32'd2 || overflow !== 1'b0 || zero !== 1'b0) begin failures++;
            $display("FAIL divu_basic lo=%h hi=%h ovf=%b zero=%b expected 0000000e 00000002 0 0", lo, hi, overflow, zero); end
    endtask

    task automatic test_busy_ignore();
        int c;
        @(negedge clk);
        opSel = OP_MULTU; operand1 = 32'd6; operand2 = 32'd7; shamt = '0; start = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            c++;
            if (c == 1) begin
                checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++;
                    $display("FAIL busy_after_accept busy=%b done=%b expected 1 0", busy, done); end
            end
            if (c == 5) begin
                opSel = OP_ADD; operand1 = 32'd99; operand2 = 32'd1; start = 1'b1;
            end
            if (c == 6) begin
                checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++;
                    $display("FAIL start_while_busy busy=%b done=%b expected 1 0", busy, done); end
            end
        end while (!done && c < 200);
        checks++; if (c !== 34 || lo !== 32'd42 || hi !== 32'd0 || result !== 32'd42) begin failures++;
            $display("FAIL busy_ignore_result cycles=%0d lo=%h hi=%h result=%h expected 34 0000002a 0 0000002a",
                     c, lo, hi, result); end
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL busy_in_done busy=%b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int c;
        @(negedge clk);
        opSel = OP_ADD; operand1 = 32'd1; operand2 = 32'd2; shamt = '0; start = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b1 || result !== 32'd3) begin failures++;
            $display("FAIL b2b_first done=%b result=%h expected 1 00000003", done, result); end
        opSel = OP_SUB; operand1 = 32'd10; operand2 = 32'd3;
        @(negedge clk);
        checks++; if (done !== 1'b1 || result !== 32'd7) begin failures++;
            $display("FAIL b2b_second done=%b result=%h expected 1 00000007", done, result); end
        opSel = OP_MULTU; operand1 = 32'd2; operand2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++;
            $display("FAIL b2b_into_mul busy=%b done=%b expected 1 0", busy, done); end
        c = 1;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
        end
        checks++; if (c !== 34 || lo !== 32'd6) begin failures++;
            $display("FAIL b2b_mul_result cycles=%0d lo=%h expected 34 00000006", c, lo); end
    endtask

    task automatic test_reset_mid();
        int c;
        @(negedge clk);
        opSel = OP_MULT; operand1 = 32'd5; operand2 = 32'd5; shamt = '0; start = 1'b1;
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++; if (busy !== 1'b1 || lo !== 32'd6) begin failures++;
            $display("FAIL pre_reset_state busy=%b lo=%h expected 1 00000006", busy, lo); end
        rst = 1'b1;
        #1;
        checks++; if (result !== 0 || hi !== 0 || lo !== 0 ||
                      {zero, overflow, divByZero, busy, done} !== 5'b10000) begin failures++;
            $display("FAIL reset_mid result=%h hi=%h lo=%h flags=%b expected 0 0 0 10000",
                     result, hi, lo, {zero, overflow, divByZero, busy, done}); end
        @(negedge clk);
        rst = 1'b0;
        run_op(OP_MFLO, 32'h0, 32'h0, 5'd0, c);
        checks++; if (result !== 32'h0 || zero !== 1'b1) begin failures++;
            $display("FAIL mflo_after_reset result=%h zero=%b expected 0 1", result, zero); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_mult();
        test_div_zero();
        test_div();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, multi-cycle successor to the datapath's single-cycle ALU. It executes the existing one-cycle integer ops and adds iterative signed/unsigned multiply and divide, which write a HI/LO register pair. A start/busy/done handshake lets the control unit stall the pipeline. It sits in the execute stage of the next-generation MIPS-style core.

## Interface
- DATA_WIDTH, 32, operand/result width; even, ≥ 8
- SEL_WIDTH, 4, opSel width
- SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when accepting (IDLE or DONE)
- opSel  in  SEL_WIDTH  operation select, latched with start
- operand1, operand2  in  DATA_WIDTH  operands, latched with start
- shamt  in  SHAMT_WIDTH  shift amount, latched with start
- result  out  DATA_WIDTH  registered result; held until the next accepted op
- hi, lo  out  DATA_WIDTH  architectural HI/LO; change only on MUL/DIV completion
- zero  out  1  result == 0, registered with result
- overflow  out  1  signed overflow (see Operation), registered
- divByZero  out  1  last DIV/DIVU had operand2 == 0
- busy  out  1  operation in flight; start ignored
- done  out  1  one-cycle pulse: result/hi/lo valid

## Operation
- Codes: ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0100, SGT 0101, NOR 0110, XOR 0111, SLL 1000, SRL 1001, MULT 1010, MULTU 1011, DIV 1100, DIVU 1101, MFHI 1110, MFLO 1111.
- ADD/SUB: overflow = two's-complement signed overflow (operand signs vs. result sign), not carry-out; result wraps modulo 2^DATA_WIDTH.
- SLT/SGT signed compare, result 0 or 1. SLL/SRL shift operand2 by shamt, zero fill.
- MFHI/MFLO: result = hi/lo, single cycle.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE/DONE + start + single-cycle op → DONE.
  - IDLE/DONE + start + MULT/MULTU → MUL; + DIV/DIVU → DIV.
  - DONE without start → IDLE.
- MUL/DIV iterate on magnitudes. Signed ops take absolute values at acceptance.
  - MUL: shift-add, one bit per cycle, 2·DATA_WIDTH product.
  - DIV: restoring, one bit per cycle.
  - Counter runs DATA_WIDTH cycles, then FIX.
- FIX applies signs, writes {hi,lo} → DONE.
  - MULT: {hi,lo} = signed product. DIV: lo = quotient truncated toward zero, hi = remainder with dividend's sign.
- Divide by zero: no iteration, straight to FIX. lo = all-ones, hi = operand1, divByZero = 1.
- Signed DIV of most-negative by −1: lo = most-negative, hi = 0, overflow = 1.
- For MUL/DIV, result = lo and zero reflects lo. overflow is 0 except for the case above.

## Timing
- Reset values: result, hi, lo = 0; zero = 1; overflow, divByZero, busy, done = 0; state IDLE.
- Single-cycle ops: start accepted at edge N; done = 1 and result valid after edge N+1. Latency 1.
- MUL/DIV: busy = 1 from edge N+1 through the FIX cycle. done after edge N+DATA_WIDTH+2.
- Divide by zero: done after edge N+2.
- busy is 0 in IDLE and DONE. start in DONE is accepted, so back-to-back ops lose no cycle.
- Inputs are don't-care while busy; the latched copies are used.
- Reset mid-operation: immediate return to reset values. hi/lo are cleared, and the partial result is discarded.

## Structure
- Shared package alu_pkg: opcode localparams, state enum, and a classification function (is_single, is_mul, is_div, is_signed).
- One sub-module, alu_comb: the existing single-cycle op set, widened by DATA_WIDTH, with the signed-overflow fix.
- Top level holds the FSM, iteration counter, magnitude/sign registers, and HI/LO.

## Test plan
- Reset, then ADD 0x7FFFFFFF + 1 → result 0x80000000, overflow 1, done at cycle 1. SUB 5−5 → zero 1.
- MULT −3 × 7 → {hi,lo} = 0xFFFFFFFF_FFFFFFEB, done at cycle 34. MULTU 0xFFFFFFFF² → hi 0xFFFFFFFE, lo 0x00000001.
- DIV −7 / 2 → lo 0xFFFFFFFD, hi 0xFFFFFFFF. DIV 0x80000000 / −1 → lo 0x80000000, hi 0, overflow 1.
- DIVU 9 / 0 → lo 0xFFFFFFFF, hi 9, divByZero 1, done at cycle 2. A following MFHI returns 9.
- start pulsed while busy is ignored; start asserted in DONE is accepted with no gap cycle.
- rst asserted mid-MULT → all outputs return to reset values; a following MFLO returns 0.
